// File: rtl/uncore_busctl.sv
// uncore_busctl: request/acknowledge bus controller for the uncore targets
// (firmware ROM, RAM, MMIO). Decodes the top address bits into a one-hot
// target select, runs a registered access with wait-state tolerance and
// reports unmapped, read-only-write and timeout faults with the completion.
module uncore_busctl #(
  parameter int                 AD_LEN      = 32,
  parameter int                 BUS_WIDTH   = 32,
  parameter int                 N_TGT       = 4,
  parameter logic [N_TGT-1:0]   TGT_PRESENT = 4'b0011,
  parameter logic [N_TGT-1:0]   TGT_RO      = 4'b0001,
  parameter int                 TIMEOUT     = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [AD_LEN-1:0]          ad_i,
  input  logic [BUS_WIDTH-1:0]       data_i,
  output logic                       ready_o,
  output logic                       ack_o,
  output logic                       err_o,
  output logic [BUS_WIDTH-1:0]       data_o,
  output logic [N_TGT-1:0]           tgt_sel_o,
  output logic                       tgt_we_o,
  output logic [AD_LEN-1:0]          tgt_ad_o,
  output logic [BUS_WIDTH-1:0]       tgt_data_o,
  input  logic [N_TGT*BUS_WIDTH-1:0] tgt_data_i,
  input  logic [N_TGT-1:0]           tgt_ack_i
);

  localparam int TGT_BITS = $clog2(N_TGT);
  localparam int CNT_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_nxt;
  logic [TGT_BITS-1:0] t_dec;
  logic [TGT_BITS-1:0] t_q;
  logic [CNT_W-1:0]    cnt;
  logic                accept;
  logic                dec_fault;
  logic                ack_hit;
  logic                tmo;

  // Wait counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  assign t_dec   = ad_i[AD_LEN-1 -: TGT_BITS];
  assign ready_o = (state == IDLE);

  // Next-state logic plus the per-cycle events that steer the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    dec_fault = 1'b0;
    ack_hit   = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          accept    = 1'b1;
          dec_fault = !TGT_PRESENT[t_dec] || (we_i && TGT_RO[t_dec]);
          state_nxt = dec_fault ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        // Only the selected target's ack counts; an ack beats a timeout.
        ack_hit = tgt_ack_i[t_q];
        tmo     = !ack_hit && (cnt == CNT_W'(TIMEOUT - 1));
        if (ack_hit || tmo) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Registered target access, wait counter and master-side completion.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
      data_o     <= '0;
      tgt_sel_o  <= '0;
      tgt_we_o   <= 1'b0;
      tgt_ad_o   <= '0;
      tgt_data_o <= '0;
      t_q        <= '0;
      cnt        <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      if (accept) begin
        tgt_we_o   <= we_i;
        tgt_ad_o   <= ad_i;
        tgt_data_o <= data_i;
        t_q        <= t_dec;
        cnt        <= '0;
        if (dec_fault) begin
          ack_o     <= 1'b1;
          err_o     <= 1'b1;
          data_o    <= '0;
          tgt_sel_o <= '0;
        end else begin
          tgt_sel_o <= N_TGT'(1) << t_dec;
        end
      end
      if (state == ACCESS) begin
        if (ack_hit) begin
          ack_o     <= 1'b1;
          tgt_sel_o <= '0;
          data_o    <= tgt_we_o ? '0 : tgt_data_i[int'(t_q)*BUS_WIDTH +: BUS_WIDTH];
        end else if (tmo) begin
          ack_o     <= 1'b1;
          err_o     <= 1'b1;
          tgt_sel_o <= '0;
          data_o    <= '0;
        end else begin
          cnt <= sat_inc(cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_uncore_busctl.sv
// Directed bench for uncore_busctl: reset, ROM read, RAM write with waits,
// decode faults, timeout boundary, spurious ack and reset mid-access.
module tb_uncore_busctl;
  localparam int AD_LEN = 32;
  localparam int BW     = 32;
  localparam int N      = 4;

  logic              clk = 1'b0;
  logic              reset_i, req_i, we_i;
  logic [AD_LEN-1:0] ad_i;
  logic [BW-1:0]     data_i;
  logic              ready_o, ack_o, err_o;
  logic [BW-1:0]     data_o;
  logic [N-1:0]      tgt_sel_o;
  logic              tgt_we_o;
  logic [AD_LEN-1:0] tgt_ad_o;
  logic [BW-1:0]     tgt_data_o;
  logic [N*BW-1:0]   tgt_data_i;
  logic [N-1:0]      tgt_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  uncore_busctl #(
    .AD_LEN(32), .BUS_WIDTH(32), .N_TGT(4),
    .TGT_PRESENT(4'b0011), .TGT_RO(4'b0001), .TIMEOUT(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
    .ad_i(ad_i), .data_i(data_i), .ready_o(ready_o), .ack_o(ack_o),
    .err_o(err_o), .data_o(data_o), .tgt_sel_o(tgt_sel_o),
    .tgt_we_o(tgt_we_o), .tgt_ad_o(tgt_ad_o), .tgt_data_o(tgt_data_o),
    .tgt_data_i(tgt_data_i), .tgt_ack_i(tgt_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in cycle 0; returns in cycle 1.
  task automatic start(input logic we, input logic [31:0] ad, input logic [31:0] d);
    req_i  = 1'b1;
    we_i   = we;
    ad_i   = ad;
    data_i = d;
    tick();
    req_i  = 1'b0;
    we_i   = 1'b0;
    data_i = '0;
  endtask

  initial begin
    int bad;
    reset_i = 1'b1; req_i = 1'b0; we_i = 1'b0; ad_i = '0; data_i = '0;
    tgt_data_i = '0; tgt_ack_i = '0;
    tick(); tick();
    check("rst_ready", ready_o, 1);
    check("rst_ack", ack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_data", data_o, 0);
    check("rst_sel", tgt_sel_o, 0);
    check("rst_we_ad_wd", {tgt_we_o, tgt_ad_o, tgt_data_o}, 0);
    reset_i = 1'b0;
    tick();

    // ROM read, ack in cycle 1.
    check("rd0_ready_c0", ready_o, 1);
    start(1'b0, 32'h0000_0010, 32'h0);
    check("rd0_sel_c1", tgt_sel_o, 4'b0001);
    check("rd0_ready_c1", ready_o, 0);
    check("rd0_ad_c1", tgt_ad_o, 32'h0000_0010);
    tgt_data_i[0*BW +: BW] = 32'hDEAD_BEEF;
    tgt_ack_i = 4'b0001;
    tick();
    tgt_ack_i = '0;
    check("rd0_ack_c2", {ack_o, err_o}, 2'b10);
    check("rd0_data_c2", data_o, 32'hDEAD_BEEF);
    check("rd0_sel_c2", tgt_sel_o, 0);
    tick();
    check("rd0_ready_c3", ready_o, 1);
    check("rd0_ack_c3", {ack_o, err_o}, 2'b00);
    check("rd0_hold_c3", data_o, 32'hDEAD_BEEF);

    // Write to the ROM: decode fault.
    start(1'b1, 32'h0000_0020, 32'h5555_AAAA);
    check("wro_ack_c1", {ack_o, err_o}, 2'b11);
    check("wro_data_c1", data_o, 0);
    check("wro_sel_c1", tgt_sel_o, 0);
    tick();
    check("wro_ready_c2", ready_o, 1);
    check("wro_ack_c2", {ack_o, err_o}, 2'b00);

    // Read an unpopulated target: decode fault.
    start(1'b0, 32'hC000_0000, 32'h0);
    check("unm_ack_c1", {ack_o, err_o}, 2'b11);
    check("unm_data_c1", data_o, 0);
    check("unm_sel_c1", tgt_sel_o, 0);
    tick();

    // RAM write, three wait cycles, ack in cycle 4.
    start(1'b1, 32'h4000_0004, 32'h1234_5678);
    check("wr1_sel_c1", tgt_sel_o, 4'b0010);
    check("wr1_we_c1", tgt_we_o, 1);
    check("wr1_wd_c1", tgt_data_o, 32'h1234_5678);
    check("wr1_ad_c1", tgt_ad_o, 32'h4000_0004);
    bad = 0;
    for (int c = 1; c <= 4; c++) begin
      if (ack_o !== 1'b0 || tgt_sel_o !== 4'b0010) bad++;
      if (c == 4) tgt_ack_i = 4'b0010;
      tick();
    end
    tgt_ack_i = '0;
    check("wr1_wait", bad, 0);
    check("wr1_ack_c5", {ack_o, err_o}, 2'b10);
    check("wr1_data_c5", data_o, 0);
    tick();

    // RAM read, ack lands in the last allowed cycle (16).
    tgt_data_i[1*BW +: BW] = 32'hCAFE_0016;
    start(1'b0, 32'h4000_0008, 32'h0);
    bad = 0;
    for (int c = 1; c <= 16; c++) begin
      if (ack_o !== 1'b0 || tgt_sel_o !== 4'b0010) bad++;
      if (c == 16) tgt_ack_i = 4'b0010;
      tick();
    end
    tgt_ack_i = '0;
    check("late_wait", bad, 0);
    check("late_ack_c17", {ack_o, err_o}, 2'b10);
    check("late_data_c17", data_o, 32'hCAFE_0016);
    tick();

    // RAM read, no ack at all: timeout.
    start(1'b0, 32'h4000_000C, 32'h0);
    bad = 0;
    for (int c = 1; c <= 16; c++) begin
      if (ack_o !== 1'b0 || tgt_sel_o !== 4'b0010) bad++;
      tick();
    end
    check("tmo_wait", bad, 0);
    check("tmo_ack_c17", {ack_o, err_o}, 2'b11);
    check("tmo_data_c17", data_o, 0);
    check("tmo_sel_c17", tgt_sel_o, 0);
    tick();
    check("tmo_ready_c18", ready_o, 1);

    // Spurious ROM ack during a RAM access is ignored.
    tgt_data_i[0*BW +: BW] = 32'h1111_1111;
    tgt_data_i[1*BW +: BW] = 32'h0BAD_F00D;
    start(1'b0, 32'h4000_0010, 32'h0);
    tgt_ack_i = 4'b0001;
    tick();
    check("spur_ack_c2", ack_o, 0);
    check("spur_sel_c2", tgt_sel_o, 4'b0010);
    tgt_ack_i = 4'b0010;
    tick();
    tgt_ack_i = '0;
    check("spur_ack_c3", {ack_o, err_o}, 2'b10);
    check("spur_data_c3", data_o, 32'h0BAD_F00D);
    tick();

    // Reset in ACCESS cycle 2 drops the transaction.
    start(1'b0, 32'h4000_0014, 32'h0);
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("rsta_sel", tgt_sel_o, 0);
    check("rsta_ready", ready_o, 1);
    check("rsta_ack", ack_o, 0);
    check("rsta_data", data_o, 0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ack_o !== 1'b0) bad++;
    end
    check("rsta_noack", bad, 0);

    // Fresh request after the reset completes normally.
    tgt_data_i[1*BW +: BW] = 32'h7777_0001;
    start(1'b0, 32'h4000_0018, 32'h0);
    check("post_sel_c1", tgt_sel_o, 4'b0010);
    tgt_ack_i = 4'b0010;
    tick();
    tgt_ack_i = '0;
    check("post_ack_c2", {ack_o, err_o}, 2'b10);
    check("post_data_c2", data_o, 32'h7777_0001);
    tick();
    check("post_ready_c3", ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
